// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the SRAM data-memory responder (sram_ctrl).
//   - state_e            : access FSM states
//   - BASE_ADDR_DEFAULT  : byte address that maps onto SRAM word 0
//   - half-word select positions inside the 32-bit data word and the
//     half-word address
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  // IDLE : waiting for a request (ready is combinational from the enables)
  // LO   : low half-word access in progress
  // HI   : high half-word access in progress
  // DONE : one-cycle release of the stalled instruction
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned BASE_ADDR_DEFAULT = 1024;

  // Width of one SRAM access.
  localparam int HALF_W = 16;

  // Bit offsets of the two halves inside the 32-bit data word.
  localparam int LO_HALF_LSB = 0;
  localparam int HI_HALF_LSB = 16;

  // Values of the half-word address LSB for each half.
  localparam logic LO_HALF_SEL = 1'b0;
  localparam logic HI_HALF_SEL = 1'b1;

endpackage : mem_ctrl_pkg

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//   Data-memory responder behind the MEM stage. Each 32-bit read or write is
//   carried out as two 16-bit accesses (low half, then high half) on an
//   external asynchronous SRAM. While an access is in flight `ready` is low so
//   the pipeline freezes; read data comes back on MEM_Out.
//
// Parameters
//   ADDR_W    : SRAM half-word address width
//   WAIT_CYC  : cycles per half-word phase (must be >= 2)
//   BASE_ADDR : byte address mapped onto SRAM word 0
//
// Ports
//   clk         in   pipeline clock, rising edge
//   rst         in   asynchronous reset, active-low
//   MEM_R_EN    in   read request
//   MEM_W_EN    in   write request (wins when both enables are high)
//   ALU_Res     in   byte address
//   Val_Rm      in   write data
//   MEM_Out     out  read data, registered
//   ready       out  high = no access in progress
//   SRAM_ADDR   out  half-word address, registered
//   SRAM_DQ_out out  write data to the pad, registered
//   SRAM_DQ_oe  out  pad output enable, registered
//   SRAM_DQ_in  in   read data from the pad
//   SRAM_WE_N   out  write strobe, active-low, registered
// -----------------------------------------------------------------------------
module sram_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 18,
  parameter int          WAIT_CYC  = 2,
  parameter int unsigned BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_Res,
  input  logic [31:0]       Val_Rm,
  output logic [31:0]       MEM_Out,
  output logic              ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]       SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  input  logic [15:0]       SRAM_DQ_in,
  output logic              SRAM_WE_N
);

  localparam int CNT_W = $clog2(WAIT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

  // The write strobe needs at least one low cycle plus one high cycle per
  // phase so the address never moves while WE_N is low.
  if (WAIT_CYC < 2) begin : g_bad_wait_cyc
    $error("sram_ctrl: WAIT_CYC must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // Address mapping: word = (ALU_Res - BASE_ADDR) >> 2 in 32-bit modulo
  // arithmetic. Keeping only the ADDR_W-1 word bits lets the half-select bit
  // be appended later, which is the same as truncating {word, half}.
  // ---------------------------------------------------------------------------
  logic [31:0]       offs;
  logic [ADDR_W-2:0] req_word;
  logic              unused_addr_bits;

  assign offs             = ALU_Res - 32'(BASE_ADDR);
  assign req_word         = offs[ADDR_W:2];
  assign unused_addr_bits = ^{offs[31:ADDR_W+1], offs[1:0]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              is_wr_q,     is_wr_d;
  logic [ADDR_W-2:0] word_q,      word_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [31:0]       mem_out_q,   mem_out_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]       dq_out_q,    dq_out_d;
  logic              dq_oe_q,     dq_oe_d;
  logic              we_n_q,      we_n_d;

  logic              req;
  logic              phase_last;

  assign req        = MEM_R_EN | MEM_W_EN;
  assign phase_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    mem_out_d   = mem_out_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;

    // -------------------------------------------------------------------------
    // Sequencing and read-data capture
    // -------------------------------------------------------------------------
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = '0;
          is_wr_d = MEM_W_EN;
          word_d  = req_word;
          wdata_d = Val_Rm;
        end
      end

      LO: begin
        if (phase_last) begin
          state_d = HI;
          cnt_d   = '0;
          // Sample at the edge that ends the last LO cycle.
          if (!is_wr_q) begin
            mem_out_d[LO_HALF_LSB +: HALF_W] = SRAM_DQ_in;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HI: begin
        if (phase_last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!is_wr_q) begin
            mem_out_d[HI_HALF_LSB +: HALF_W] = SRAM_DQ_in;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // The enables seen here still belong to the instruction just served,
      // so they are deliberately ignored.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // -------------------------------------------------------------------------
    // Pad drive for the coming cycle. All pin outputs are registered, so they
    // are derived from the next state/counter rather than the current one.
    // -------------------------------------------------------------------------
    if (state_d == LO || state_d == HI) begin
      sram_addr_d = {word_d, (state_d == HI) ? HI_HALF_SEL : LO_HALF_SEL};
      if (is_wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = (state_d == HI) ? wdata_d[HI_HALF_LSB +: HALF_W]
                                   : wdata_d[LO_HALF_LSB +: HALF_W];
        // Strobe low for all but the last cycle of the phase.
        we_n_d   = (cnt_d == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      mem_out_q   <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      mem_out_q   <= mem_out_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // In IDLE the stall must appear in the same cycle the request does, hence
  // the combinational term; DONE releases the pipeline.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = !req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign MEM_Out     = mem_out_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign SRAM_DQ_out = dq_out_q;
  assign SRAM_DQ_oe  = dq_oe_q;
  assign SRAM_WE_N   = we_n_q;

endmodule : sram_ctrl

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//   Self-checking bench for sram_ctrl. A behavioural asynchronous SRAM sits on
//   the pad side; a word-level reference memory predicts read data, and the
//   cycle-by-cycle pin/ready behaviour of each access is derived from the
//   access timing rules (2W+1 stall cycles, W cycles per half).
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

  localparam int          ADDR_W = 18;
  localparam int          W      = 2;
  localparam int unsigned BASE   = 1024;

  logic              clk;
  logic              rst;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       ALU_Res;
  logic [31:0]       Val_Rm;
  logic [31:0]       MEM_Out;
  logic              ready;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [15:0]       SRAM_DQ_out;
  logic              SRAM_DQ_oe;
  logic [15:0]       SRAM_DQ_in;
  logic              SRAM_WE_N;

  sram_ctrl #(
    .ADDR_W   (ADDR_W),
    .WAIT_CYC (W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .ALU_Res    (ALU_Res),
    .Val_Rm     (Val_Rm),
    .MEM_Out    (MEM_Out),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_oe (SRAM_DQ_oe),
    .SRAM_DQ_in (SRAM_DQ_in),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural async SRAM: stores while WE_N is low, reads combinationally.
  logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
  always @(negedge clk) begin
    if (SRAM_WE_N === 1'b0) sram_mem[SRAM_ADDR] <= SRAM_DQ_out;
  end
  assign SRAM_DQ_in = sram_mem[SRAM_ADDR];

  // Reference model: 32-bit words keyed by word index modulo SRAM depth.
  logic [31:0] ref_word [int unsigned];
  logic [31:0] exp_mem_out;

  int compared;
  int mismatched;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned word_key(input logic [31:0] a);
    logic [31:0] offs;
    offs = a - BASE;
    return (offs >> 2) % (1 << (ADDR_W - 1));
  endfunction

  // Caller is just after a rising edge with the DUT in IDLE. Returns just
  // after the rising edge that follows DONE, with both enables dropped.
  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
    int unsigned key;
    logic [31:0] lo_a;
    logic [31:0] hi_a;
    logic [31:0] exp_rd;
    int          p;
    bit          hi;
    key  = word_key(a);
    lo_a = (key * 2) % (1 << ADDR_W);
    hi_a = (key * 2 + 1) % (1 << ADDR_W);
    exp_rd = ref_word.exists(key) ? ref_word[key] : 32'hx;
    $display("access %s rd=%0b wr=%0b addr=%0d data=0x%08h", tag, rd, wr, a, d);

    MEM_R_EN = rd;
    MEM_W_EN = wr;
    ALU_Res  = a;
    Val_Rm   = d;

    @(negedge clk);
    check($sformatf("%s c0 ready", tag), 32'(ready), 32'd0);

    for (int c = 1; c <= 2 * W; c++) begin
      @(negedge clk);
      p  = (c - 1) % W;
      hi = (c > W);
      check($sformatf("%s c%0d ready", tag, c), 32'(ready), 32'd0);
      check($sformatf("%s c%0d addr", tag, c), 32'(SRAM_ADDR), hi ? hi_a : lo_a);
      check($sformatf("%s c%0d oe", tag, c), 32'(SRAM_DQ_oe), 32'(wr));
      check($sformatf("%s c%0d we_n", tag, c), 32'(SRAM_WE_N),
            32'(!(wr && p != W - 1)));
      if (wr) check($sformatf("%s c%0d dq_out", tag, c), 32'(SRAM_DQ_out),
                    hi ? 32'(d[31:16]) : 32'(d[15:0]));
    end

    if (wr) ref_word[key] = d;
    else    exp_mem_out   = exp_rd;

    @(negedge clk);
    check($sformatf("%s done ready", tag), 32'(ready), 32'd1);
    check($sformatf("%s done oe", tag), 32'(SRAM_DQ_oe), 32'd0);
    check($sformatf("%s done we_n", tag), 32'(SRAM_WE_N), 32'd1);
    check($sformatf("%s done mem_out", tag), MEM_Out, exp_mem_out);

    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle ready", tag), 32'(ready), 32'd1);
      check($sformatf("%s idle oe", tag), 32'(SRAM_DQ_oe), 32'd0);
      check($sformatf("%s idle we_n", tag), 32'(SRAM_WE_N), 32'd1);
      check($sformatf("%s idle mem_out", tag), MEM_Out, exp_mem_out);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s rst mem_out", tag), MEM_Out, 32'd0);
    check($sformatf("%s rst addr", tag), 32'(SRAM_ADDR), 32'd0);
    check($sformatf("%s rst dq_out", tag), 32'(SRAM_DQ_out), 32'd0);
    check($sformatf("%s rst oe", tag), 32'(SRAM_DQ_oe), 32'd0);
    check($sformatf("%s rst we_n", tag), 32'(SRAM_WE_N), 32'd1);
    check($sformatf("%s rst ready", tag), 32'(ready), 32'd1);
  endtask

  // Start a write, pull reset mid-cycle in cycle `cyc`, then release it.
  task automatic reset_mid_write(input string tag, input int cyc,
                                 input logic [31:0] a, input logic [31:0] d);
    $display("access %s reset in cycle %0d of write addr=%0d data=0x%08h", tag, cyc, a, d);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b1;
    ALU_Res  = a;
    Val_Rm   = d;
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst      = 1'b0;
    MEM_W_EN = 1'b0;
    #1;
    check_reset_values(tag);
    exp_mem_out = 32'd0;
    ref_word.delete(word_key(a));
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned key;
    int          op;
    logic [31:0] a;

    compared    = 0;
    mismatched  = 0;
    exp_mem_out = 32'd0;
    rst      = 1'b0;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_Res  = 32'd0;
    Val_Rm   = 32'd0;

    repeat (3) @(posedge clk);
    #2;
    check_reset_values("por");
    rst = 1'b1;
    @(posedge clk);
    #1;

    idle_cycles("start", 2);

    // Directed cases
    access("wr1028", 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF);
    access("rd1028", 1'b1, 1'b0, 32'd1028, 32'h0);
    // back-to-back: next request presented with no idle cycle in between
    access("wr1032", 1'b0, 1'b1, 32'd1032, 32'h1234_5678);
    access("rd1032", 1'b1, 1'b0, 32'd1032, 32'h0);
    access("both1036", 1'b1, 1'b1, 32'd1036, 32'hA5A5_A5A5);
    access("rd1036", 1'b1, 1'b0, 32'd1036, 32'h0);
    access("wr1020", 1'b0, 1'b1, 32'd1020, 32'h0BAD_F00D);
    access("rd1023", 1'b1, 1'b0, 32'd1023, 32'h0);
    idle_cycles("mid", 3);

    reset_mid_write("abort2", 2, 32'd1100, 32'hCAFE_0001);
    access("post_rst_wr", 1'b0, 1'b1, 32'd1040, 32'h7777_1111);
    access("post_rst_rd", 1'b1, 1'b0, 32'd1040, 32'h0);
    reset_mid_write("abort3", 3, 32'd1104, 32'hCAFE_0002);
    access("rd1028_again", 1'b1, 1'b0, 32'd1028, 32'h0);

    // Randomised traffic over a small window that straddles BASE_ADDR
    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 3));
      a   = BASE - 32'd16 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      key = word_key(a);
      if (op == 0) begin
        idle_cycles($sformatf("rnd%0d", i), int'($urandom_range(1, 2)));
      end else if (op == 1 && ref_word.exists(key)) begin
        access($sformatf("rnd%0d", i), 1'b1, 1'b0, a, 32'($urandom));
      end else if (op == 3) begin
        access($sformatf("rnd%0d", i), 1'b1, 1'b1, a, 32'($urandom));
      end else begin
        access($sformatf("rnd%0d", i), 1'b0, 1'b1, a, 32'($urandom));
      end
    end

    idle_cycles("end", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_sram_ctrl

// File: doc/sram_ctrl.md
# sram_ctrl

Data-memory responder at the far end of the MEM stage's request interface. It accepts single-word read/write requests (MEM_R_EN / MEM_W_EN, byte address in ALU_Res, store data in Val_Rm) and performs each one as two 16-bit accesses on an external asynchronous SRAM. While an access is in flight it drives `ready` low; the hazard/freeze logic uses `ready` to stall the pipeline. Read data is returned on MEM_Out.

## Interface
Parameters:
- ADDR_W, 18, SRAM half-word address width.
- WAIT_CYC, 2, cycles per half-word phase. Minimum 2; values below 2 are illegal and rejected by elaboration assertion.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- MEM_R_EN  in  1  read request.
- MEM_W_EN  in  1  write request.
- ALU_Res  in  32  byte address.
- Val_Rm  in  32  write data.
- MEM_Out  out  32  read data, registered.
- ready  out  1  high = no access in progress; low = pipeline must freeze.
- SRAM_ADDR  out  ADDR_W  half-word address, registered.
- SRAM_DQ_out  out  16  write data to pad, registered.
- SRAM_DQ_oe  out  1  pad output enable, registered.
- SRAM_DQ_in  in  16  read data from pad.
- SRAM_WE_N  out  1  write strobe, active-low, registered.

## Operation
- Address mapping: word = (ALU_Res − BASE_ADDR) >> 2, computed in 32-bit modulo arithmetic. Low half address = {word, 0}; high half address = {word, 1}. Both are truncated to ADDR_W bits. ALU_Res[1:0] is ignored.
- FSM states:
  - IDLE: `ready` = !(MEM_R_EN | MEM_W_EN), combinational. On a request, capture the op (write if MEM_W_EN, else read), address and Val_Rm, then go to LO.
  - LO: WAIT_CYC cycles, then go to HI.
  - HI: WAIT_CYC cycles, then go to DONE.
  - DONE: one cycle, then go to IDLE. Requests are ignored in DONE; these are still the stalled instruction's enables.
- `ready` is low in LO and HI, and high in DONE.
- Write phase:
  - SRAM_DQ_oe=1 for the whole phase.
  - SRAM_DQ_out = Val_Rm[15:0] in LO, Val_Rm[31:16] in HI.
  - SRAM_WE_N=0 for the first WAIT_CYC−1 cycles of the phase and 1 in the last cycle, so the address never changes while WE_N is low.
- Read phase: SRAM_DQ_oe=0, SRAM_WE_N=1. SRAM_DQ_in is sampled at the clock edge ending the last cycle of LO (into MEM_Out[15:0]) and of HI (into MEM_Out[31:16]).
- MEM_Out holds its value until the next read overwrites it. Writes never change MEM_Out.
- MEM_R_EN and MEM_W_EN both high: the request is treated as a write; MEM_Out is unchanged.
- Reset values: MEM_Out=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1, FSM=IDLE, wait counter=0. `ready` follows the IDLE rule.
- Reset asserted mid-access: the access is aborted and WE_N goes high asynchronously. A partial write of the low half only is acceptable. Nothing is retried.

## Timing
- Request first visible in cycle 0 (IDLE).
- LO occupies cycles 1..W and HI occupies cycles W+1..2W (W = WAIT_CYC). DONE is cycle 2W+1.
- `ready` is low in cycles 0..2W: 2W+1 stall cycles, which is 5 at the default.
- MEM_Out is valid from cycle 2W+1 and is captured by MEM2WB at the end of that cycle.
- Back-to-back accesses: the next request is seen in IDLE in cycle 2W+2, with no bubble beyond that.
- No request: zero-latency pass-through; `ready` stays 1 and SRAM pins stay idle (oe=0, WE_N=1).

## Structure
- Package `mem_ctrl_pkg` holds:
  - the FSM state enum (IDLE, LO, HI, DONE);
  - the BASE_ADDR default;
  - the half-select bit positions.
- Single flat module; no RTL sub-module. Wait counter is $clog2(WAIT_CYC+1) bits.
- The bench provides a behavioural async SRAM model, `sram_model` (16-bit, 2^ADDR_W entries, write on WE_N low, combinational read).

## Test plan
- Write 0xDEADBEEF to ALU_Res=1028 → SRAM_ADDR=2 with DQ_out=0xBEEF, then SRAM_ADDR=3 with DQ_out=0xDEAD; WE_N low in cycles 1 and 3; `ready` low in cycles 0–4.
- Read ALU_Res=1028 after that write → MEM_Out=0xDEADBEEF in cycle 5; oe=0 and WE_N=1 throughout.
- Back-to-back write to 1032 then read from 1032 with 0x12345678 → second request starts in cycle 6; read returns 0x12345678 in cycle 11.
- Both enables high, Val_Rm=0xA5A5A5A5 at 1036 → memory is written; MEM_Out keeps its previous value.
- ALU_Res=1020 (below BASE_ADDR) → SRAM_ADDR=0x3FFFE, then 0x3FFFF (wrap via truncation).
- rst low in cycle 2 of a write → WE_N=1 and `ready`=1 immediately; all outputs at reset values; a new request after release completes normally.
